// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the datapath/memory.
// The master side is the sequencer; the slave side is the datapath plus shared memory.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       op;
  logic             zero;
  logic             neg;
  logic             mem_ready;
  logic             mem_req;
  logic             iord;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       PCsrc;
  logic [2:0]       ALUOp;
  logic             alucsrc;
  logic             wreg;
  logic             m2reg;
  logic             jal;
  logic             wmem;
  logic             memc;
  logic             instr_done;
  logic [CNT_W-1:0] retired;

  modport master (
    input  op, zero, neg, mem_ready,
    output mem_req, iord, ir_we, pc_we, PCsrc, ALUOp, alucsrc,
           wreg, m2reg, jal, wmem, memc, instr_done, retired
  );

  modport slave (
    output op, zero, neg, mem_ready,
    input  mem_req, iord, ir_we, pc_we, PCsrc, ALUOp, alucsrc,
           wreg, m2reg, jal, wmem, memc, instr_done, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB phases for the 16-bit CPU,
// sharing one memory port between fetch and data access, with a retire counter.
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;

  logic       mem_req, iord, ir_we, pc_we;
  logic [1:0] pc_src;
  logic [2:0] alu_op;
  logic       alu_src, wreg, m2reg, jal, wmem, memc, instr_done;
  logic       taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (instr_done) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  // op[3]=ALU (op[2]=immediate form), op[3:2]=01 load/store (op[1]=store, op[0]=word),
  // op[3:2]=00 control transfer: jal, jalr, beq, ble.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    alu_op     = 3'b000;
    alu_src    = 1'b0;
    wreg       = 1'b0;
    m2reg      = 1'b0;
    jal        = 1'b0;
    wmem       = 1'b0;
    memc       = 1'b0;
    instr_done = 1'b0;
    taken      = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        memc    = 1'b1;
        if (bus.mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (bus.op[3]) begin
          alu_op  = {1'b0, bus.op[1:0]};
          alu_src = bus.op[2];
          state_d = S_WB;
        end else if (bus.op[2]) begin
          alu_src = 1'b1;
          state_d = S_MEM;
        end else begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
          case (bus.op[1:0])
            2'b00: begin
              pc_we  = 1'b1;
              pc_src = 2'b01;
              wreg   = 1'b1;
              jal    = 1'b1;
            end
            2'b01: begin
              alu_src = 1'b1;
              pc_we   = 1'b1;
              pc_src  = 2'b10;
              wreg    = 1'b1;
              jal     = 1'b1;
            end
            default: begin
              alu_op = 3'b001;
              taken  = bus.op[0] ? (bus.zero | bus.neg) : bus.zero;
              pc_we  = taken;
              pc_src = taken ? 2'b01 : 2'b00;
            end
          endcase
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        alu_src = 1'b1;
        memc    = bus.op[0];
        wmem    = bus.op[1];
        if (bus.mem_ready) begin
          instr_done = bus.op[1];
          state_d    = bus.op[1] ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        // Only ALU ops and loads reach WB; keep the ALU operands they had in EXEC.
        wreg       = 1'b1;
        instr_done = 1'b1;
        m2reg      = ~bus.op[3];
        alu_op     = bus.op[3] ? {1'b0, bus.op[1:0]} : 3'b000;
        alu_src    = bus.op[3] ? bus.op[2] : 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_req    = mem_req;
  assign bus.iord       = iord;
  assign bus.ir_we      = ir_we;
  assign bus.pc_we      = pc_we;
  assign bus.PCsrc      = pc_src;
  assign bus.ALUOp      = alu_op;
  assign bus.alucsrc    = alu_src;
  assign bus.wreg       = wreg;
  assign bus.m2reg      = m2reg;
  assign bus.jal        = jal;
  assign bus.wmem       = wmem;
  assign bus.memc       = memc;
  assign bus.instr_done = instr_done;
  assign bus.retired    = retired_q;

endmodule
